// File: rtl/maxnet_iter_ctrl.sv
// Maxnet iteration sequencer: loads activations, issues competition steps until a single
// survivor, all-zero, or iteration timeout, then presents the winning label on a valid/ready port.
module maxnet_iter_ctrl #(
    parameter int MAX_ITER = 64,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          load,
    output logic          step_req,
    input  logic          step_ack,
    input  logic [31:0]   x1,
    input  logic [31:0]   x2,
    input  logic [31:0]   x3,
    input  logic [31:0]   x4,
    input  logic [31:0]   a1,
    input  logic [31:0]   a2,
    input  logic [31:0]   a3,
    input  logic [31:0]   a4,
    output logic [31:0]   out,
    output logic [1:0]    out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err_allzero,
    output logic          err_timeout,
    output logic [CW-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   out_q, out_nx;
    logic [1:0]    idx_q, idx_nx;
    logic          az_q, az_nx;
    logic          to_q, to_nx;
    logic [CW-1:0] iter_q, iter_nx;

    // Sign bit is ignored so that -0 counts as zero.
    logic [3:0] nz;
    logic [2:0] nz_cnt;
    assign nz[0]  = |x1[30:0];
    assign nz[1]  = |x2[30:0];
    assign nz[2]  = |x3[30:0];
    assign nz[3]  = |x4[30:0];
    assign nz_cnt = {2'b00, nz[0]} + {2'b00, nz[1]} + {2'b00, nz[2]} + {2'b00, nz[3]};

    // Highest-index non-zero activation; with a single survivor this is that survivor.
    logic [1:0]  win_idx;
    logic [31:0] win_lbl;
    always_comb begin
        win_idx = 2'd0;
        win_lbl = a1;
        if (nz[3]) begin
            win_idx = 2'd3;
            win_lbl = a4;
        end else if (nz[2]) begin
            win_idx = 2'd2;
            win_lbl = a3;
        end else if (nz[1]) begin
            win_idx = 2'd1;
            win_lbl = a2;
        end
    end

    localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITER);
    localparam logic [CW-1:0] ITER_SAT   = {CW{1'b1}};

    always_comb begin
        state_nx = state;
        out_nx   = out_q;
        idx_nx   = idx_q;
        az_nx    = az_q;
        to_nx    = to_q;
        iter_nx  = iter_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    iter_nx  = '0;
                    az_nx    = 1'b0;
                    to_nx    = 1'b0;
                end
            end
            S_LOAD: state_nx = S_CHECK;
            S_CHECK: begin
                if (nz_cnt == 3'd0) begin
                    state_nx = S_DONE;
                    out_nx   = '0;
                    idx_nx   = 2'd0;
                    az_nx    = 1'b1;
                end else if (nz_cnt == 3'd1) begin
                    state_nx = S_DONE;
                    out_nx   = win_lbl;
                    idx_nx   = win_idx;
                end else if (iter_q == ITER_LIMIT) begin
                    state_nx = S_DONE;
                    out_nx   = win_lbl;
                    idx_nx   = win_idx;
                    to_nx    = 1'b1;
                end else begin
                    state_nx = S_STEP;
                end
            end
            S_STEP: state_nx = S_WAIT;
            S_WAIT: begin
                if (step_ack) begin
                    state_nx = S_CHECK;
                    iter_nx  = (iter_q == ITER_SAT) ? iter_q : iter_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            out_q  <= '0;
            idx_q  <= 2'd0;
            az_q   <= 1'b0;
            to_q   <= 1'b0;
            iter_q <= '0;
        end else begin
            state  <= state_nx;
            out_q  <= out_nx;
            idx_q  <= idx_nx;
            az_q   <= az_nx;
            to_q   <= to_nx;
            iter_q <= iter_nx;
        end
    end

    // Decoded straight from state so that reset removes them without waiting for a clock.
    assign busy        = (state != S_IDLE);
    assign load        = (state == S_LOAD);
    assign step_req    = (state == S_STEP) || (state == S_WAIT);
    assign out_valid   = (state == S_DONE);
    assign out         = out_q;
    assign out_idx     = idx_q;
    assign err_allzero = az_q;
    assign err_timeout = to_q;
    assign iter_count  = iter_q;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Directed bench for maxnet_iter_ctrl; the bench plays the datapath, acking each step after 3 cycles.
module tb_maxnet_iter_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, load, step_req;
    logic          step_ack = 1'b0;
    logic [31:0]   x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic [31:0]   a1 = '0, a2 = '0, a3 = '0, a4 = '0;
    logic [31:0]   out;
    logic [1:0]    out_idx;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          err_allzero, err_timeout;
    logic [CW-1:0] iter_count;

    int checks = 0;
    int failures = 0;
    int step_edges = 0;
    int xfers = 0;
    int base_steps, base_xfers;
    logic step_q = 1'b0;

    maxnet_iter_ctrl #(.MAX_ITER(4), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .load(load),
        .step_req(step_req), .step_ack(step_ack),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .out(out), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .err_allzero(err_allzero), .err_timeout(err_timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        step_q <= step_req;
        if (step_req && !step_q) step_edges <= step_edges + 1;
        if (out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_step_req();
        int n = 0;
        while (step_req !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) begin
            checks++;
            failures++;
            $display("FAIL step_req_wait got=0 exp=1");
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) begin
            checks++;
            failures++;
            $display("FAIL out_valid_wait got=0 exp=1");
        end
    endtask

    task automatic do_step(input logic [31:0] n1, input logic [31:0] n2,
                           input logic [31:0] n3, input logic [31:0] n4);
        wait_step_req();
        tick();
        tick();
        chk("step_req_held", {31'd0, step_req}, 32'd1);
        tick();
        x1 = n1; x2 = n2; x3 = n3; x4 = n4;
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        chk("step_req_drop", {31'd0, step_req}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_step_req", {31'd0, step_req}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {30'd0, err_allzero, err_timeout}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_idx", {30'd0, out_idx}, 32'd0);
        chk("rst_iter", {24'd0, iter_count}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single survivor at load, exact latency, 1-cycle valid with ready high
        x1 = 32'h0; x2 = 32'h3F800000; x3 = 32'h0; x4 = 32'h0;
        a1 = 32'd11; a2 = 32'd22; a3 = 32'd33; a4 = 32'd44;
        base_steps = step_edges;
        pulse_start();
        chk("t1_load_c1", {31'd0, load}, 32'd1);
        chk("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_load_c2", {31'd0, load}, 32'd0);
        chk("t1_valid_c2", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid_c3", {31'd0, out_valid}, 32'd1);
        chk("t1_out", out, 32'd22);
        chk("t1_idx", {30'd0, out_idx}, 32'd1);
        chk("t1_iter", {24'd0, iter_count}, 32'd0);
        chk("t1_flags", {30'd0, err_allzero, err_timeout}, 32'd0);
        tick();
        chk("t1_valid_c4", {31'd0, out_valid}, 32'd0);
        chk("t1_busy_c4", {31'd0, busy}, 32'd0);
        chk("t1_steps", step_edges - base_steps, 32'd0);

        // 2: convergence after two steps
        x1 = 32'h3F000000; x2 = 32'h3F800000; x3 = 32'h0; x4 = 32'h0;
        a1 = 32'd5; a2 = 32'd6; a3 = 32'd7; a4 = 32'd8;
        base_steps = step_edges;
        pulse_start();
        do_step(32'h3E800000, 32'h3F600000, 32'h0, 32'h0);
        do_step(32'h0, 32'h3F400000, 32'h0, 32'h0);
        wait_valid();
        chk("t2_out", out, 32'd6);
        chk("t2_idx", {30'd0, out_idx}, 32'd1);
        chk("t2_iter", {24'd0, iter_count}, 32'd2);
        chk("t2_flags", {30'd0, err_allzero, err_timeout}, 32'd0);
        tick();
        chk("t2_steps", step_edges - base_steps, 32'd2);

        // 3: all zero including -0
        x1 = 32'h80000000; x2 = 32'h0; x3 = 32'h0; x4 = 32'h0;
        base_steps = step_edges;
        pulse_start();
        tick();
        tick();
        chk("t3_valid_c3", {31'd0, out_valid}, 32'd1);
        chk("t3_allzero", {31'd0, err_allzero}, 32'd1);
        chk("t3_timeout", {31'd0, err_timeout}, 32'd0);
        chk("t3_out", out, 32'd0);
        chk("t3_idx", {30'd0, out_idx}, 32'd0);
        tick();
        chk("t3_steps", step_edges - base_steps, 32'd0);

        // 4: timeout at MAX_ITER=4, flags from the previous run cleared on start
        x1 = 32'h0; x2 = 32'h0; x3 = 32'h3F800000; x4 = 32'h40000000;
        a1 = 32'd100; a2 = 32'd200; a3 = 32'd300; a4 = 32'd400;
        base_steps = step_edges;
        pulse_start();
        tick();
        chk("t4_allzero_cleared", {31'd0, err_allzero}, 32'd0);
        for (int i = 0; i < 4; i++) do_step(32'h0, 32'h0, 32'h3F800000, 32'h40000000);
        wait_valid();
        chk("t4_timeout", {31'd0, err_timeout}, 32'd1);
        chk("t4_allzero", {31'd0, err_allzero}, 32'd0);
        chk("t4_out", out, 32'd400);
        chk("t4_idx", {30'd0, out_idx}, 32'd3);
        chk("t4_iter", {24'd0, iter_count}, 32'd4);
        tick();
        chk("t4_steps", step_edges - base_steps, 32'd4);

        // 5: backpressure, start during DONE and start coincident with the handshake
        out_ready = 1'b0;
        x1 = 32'h0; x2 = 32'h0; x3 = 32'h40000000; x4 = 32'h0;
        a3 = 32'd33;
        pulse_start();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_valid_hold", {31'd0, out_valid}, 32'd1);
            chk("t5_out_hold", out, 32'd33);
            chk("t5_idx_hold", {30'd0, out_idx}, 32'd2);
            chk("t5_flags_hold", {30'd0, err_allzero, err_timeout}, 32'd0);
            start = (i == 4);
            tick();
        end
        base_xfers = xfers;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_valid_after", {31'd0, out_valid}, 32'd0);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        chk("t5_out_retained", out, 32'd33);
        tick();
        chk("t5_xfers", xfers - base_xfers, 32'd1);
        chk("t5_start_dropped", {31'd0, busy}, 32'd0);

        // 6: async reset while waiting for an ack
        x1 = 32'h3F800000; x2 = 32'h3F800000; x3 = 32'h0; x4 = 32'h0;
        pulse_start();
        wait_step_req();
        tick();
        chk("t6_in_wait", {31'd0, step_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_step_req_async", {31'd0, step_req}, 32'd0);
        chk("t6_busy_async", {31'd0, busy}, 32'd0);
        chk("t6_load_async", {31'd0, load}, 32'd0);
        tick();
        rst = 1'b0;
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        chk("t6_ack_ignored_busy", {31'd0, busy}, 32'd0);
        chk("t6_ack_ignored_iter", {24'd0, iter_count}, 32'd0);
        tick();
        chk("t6_idle", {31'd0, busy}, 32'd0);
        x1 = 32'h0; x2 = 32'h0; x3 = 32'h0; x4 = 32'h3F800000;
        a4 = 32'd44;
        pulse_start();
        tick();
        tick();
        chk("t6_rerun_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_rerun_out", out, 32'd44);
        chk("t6_rerun_idx", {30'd0, out_idx}, 32'd3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxnet_iter_ctrl.md
Name: maxnet_iter_ctrl

Overview:
- Iteration sequencer at the driving end of the Maxnet winner-check path.
- Loads the four activations into the datapath, then issues competition steps until one of three outcomes: exactly one activation is non-zero, all are zero, or an iteration limit is reached.
- Presents the winning label on a valid/ready output port with error flags.
- Sits between the top-level start interface and the float datapath that produces x1..x4.

Parameters:
- MAX_ITER, 64, maximum number of competition steps before timeout (1..255).
- CW, 8, width of the iteration counter; must satisfy 2^CW > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- load  out  1  one-cycle pulse; datapath captures its initial activations.
- step_req  out  1  held high until step_ack; requests one Maxnet update.
- step_ack  in  1  datapath has completed the update; x1..x4 are updated and stable from this cycle.
- x1, x2, x3, x4  in  32  current activations, IEEE-754 single precision.
- a1, a2, a3, a4  in  32  labels associated with x1..x4.
- out  out  32  winning label.
- out_idx  out  2  winner index: 0 for x1 through 3 for x4.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- err_allzero  out  1  run ended with every activation zero.
- err_timeout  out  1  run ended by MAX_ITER.
- iter_count  out  CW  steps performed in the current or last run.

Behaviour:
- Reset values:
  - State is IDLE.
  - busy, load, step_req, out_valid, err_allzero and err_timeout are all 0.
  - out is 0, out_idx is 0 and iter_count is 0.
- Zero test: nz_i = |x_i[30:0].
  - +0 and -0 both count as zero.
  - Any other encoding, including negative values, counts as non-zero.
  - nz_cnt = nz1 + nz2 + nz3 + nz4.
- IDLE:
  - On start, go to LOAD, clear iter_count and clear both error flags.
- LOAD:
  - Assert load for exactly 1 cycle, then go to CHECK.
- CHECK:
  - Sample x1..x4 and evaluate in this order; the first matching rule wins.
  - nz_cnt == 0: go to DONE with out = 0, out_idx = 0 and err_allzero = 1.
  - nz_cnt == 1: go to DONE with out = a_k and out_idx = k-1, where k is the index of the non-zero activation.
  - iter_count == MAX_ITER: go to DONE with err_timeout = 1. The winner is the highest-index non-zero activation (x4 has priority over x3, x3 over x2, x2 over x1).
  - Otherwise: go to STEP.
- STEP:
  - Raise step_req and go to WAIT.
- WAIT:
  - step_req stays high while waiting.
  - On step_ack: drop step_req the next cycle, increment iter_count (saturating at 2^CW-1) and go to CHECK.
  - step_ack seen outside WAIT is ignored.
- DONE:
  - out_valid = 1.
  - out, out_idx and both error flags are held stable until handshake.
  - Transfer happens in a cycle with out_valid & out_ready. The next cycle has out_valid = 0 and state IDLE.
  - out, out_idx and the flags are retained until the next start.
- Latency:
  - start sampled at cycle 0, load at cycle 1, CHECK at cycle 2.
  - If already decided at that point, out_valid rises at cycle 3.
  - Each step costs 2 cycles plus the datapath ack latency.
- Simultaneous and boundary cases:
  - start while busy is dropped, not queued.
  - start in the same cycle as a DONE handshake is dropped; state is still DONE in that cycle.
  - out_ready held high before DONE gives 1-cycle out_valid.
  - With MAX_ITER = 1, exactly one step is issued.
  - The counter never wraps before timeout, because MAX_ITER < 2^CW.
- Reset mid-run:
  - Immediate return to IDLE.
  - step_req and load are deasserted asynchronously.
  - Any pending datapath ack is ignored.

Test Plan:
1. Single survivor at load: x = {0, 0x3F800000, 0, 0}, a = {11, 22, 33, 44}, start. Required: out_valid at cycle 3, out = 22, out_idx = 1, iter_count = 0, no error flags.
2. Convergence over iterations: two non-zero activations initially; the datapath model acks after 3 cycles and zeroes x1 after the 2nd step. Required: exactly 2 step_req pulses, iter_count = 2, out = a2.
3. All zero, including -0: x = {0x80000000, 0, 0, 0}. Required: err_allzero = 1, out = 0, out_idx = 0, no step_req.
4. Timeout: MAX_ITER = 4 with x3 and x4 never reaching zero. Required: 4 steps, err_timeout = 1, out = a4, out_idx = 3.
5. Backpressure and dropped start: out_ready held low for 10 cycles in DONE, with start pulsed during that window. Required: out and flags stable throughout; the start is ignored; one transfer occurs when out_ready rises; IDLE on the next cycle.
6. Asynchronous reset while in WAIT with step_req high: assert rst mid-cycle. Required: step_req and busy fall immediately; a later step_ack has no effect; a new start runs normally.
